// File: rtl/rv32i_pkg.sv
// Shared RV32I encoder definitions: opcodes, instruction formats, request record
// and the opcode-to-format decoder used by the encoder pipeline.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  function automatic fmt_e decode_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_LUI, OP_AUIPC:          f = FMT_U;
      OP_JAL:                    f = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM:  f = FMT_I;
      OP_STORE:                  f = FMT_S;
      OP_BRANCH:                 f = FMT_B;
      OP_R:                      f = FMT_R;
      default:                   f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Combinational field packer: scatters the immediate into the format-specific bit
// positions. Build with IMM_RANGE_CHECK_EN to flag immediates that do not fit.
module rv32i_imm_pack
  import rv32i_pkg::*;
(
  input  fmt_e        fmt,
  input  req_t        req,
  output logic [31:0] instr,
  output logic        range_fault
);

  logic is_shift;

  // SLLI/SRLI/SRAI carry funct7 in the upper immediate bits and a 5-bit shamt.
  assign is_shift = (req.op == OP_IMM) && (req.funct3[1:0] == 2'b01);

  always_comb begin
    instr       = NOP;
    range_fault = 1'b0;

    case (fmt)
      FMT_R: instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.op};
      FMT_I: begin
        if (is_shift)
          instr = {req.funct7, req.imm[4:0], req.rs1, req.funct3, req.rd, req.op};
        else
          instr = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.op};
      end
      FMT_S: instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.op};
      FMT_B: instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                      req.imm[4:1], req.imm[11], req.op};
      FMT_U: instr = {req.imm[31:12], req.rd, req.op};
      FMT_J: instr = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                      req.rd, req.op};
      default: instr = NOP;
    endcase

`ifdef IMM_RANGE_CHECK_EN
    case (fmt)
      FMT_I: begin
        if (is_shift)
          range_fault = (req.imm[31:5] != 27'd0);
        else
          range_fault = (req.imm[31:11] != {21{req.imm[11]}});
      end
      FMT_S: range_fault = (req.imm[31:11] != {21{req.imm[11]}});
      FMT_B: range_fault = (req.imm[31:12] != {20{req.imm[12]}}) || req.imm[0];
      FMT_J: range_fault = (req.imm[31:20] != {12{req.imm[20]}}) || req.imm[0];
      FMT_U: range_fault = (req.imm[11:0] != 12'd0);
      default: range_fault = 1'b0;
    endcase
`else
    range_fault = 1'b0;
`endif
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with fault substitution and a
// saturating good-word counter. Immediate range faults need IMM_RANGE_CHECK_EN.
module rv32i_instr_encoder
  import rv32i_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_op,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  logic             s1_v_reg, s1_v_next;
  req_t             s1_req_reg, s1_req_next;
  fmt_e             s1_fmt_reg, s1_fmt_next;
  logic             s2_v_reg, s2_v_next;
  logic [31:0]      s2_instr_reg, s2_instr_next;
  logic             s2_err_reg, s2_err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  req_t        in_req;
  logic        s1_adv;
  logic        s2_adv;
  logic [31:0] packed_instr;
  logic        range_fault;
  logic        s1_err;

  assign in_req = '{op: in_op, funct3: in_funct3, funct7: in_funct7,
                    rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  // Each stage may load when its successor is empty or draining this cycle.
  assign s2_adv   = !s2_v_reg || out_ready;
  assign s1_adv   = !s1_v_reg || s2_adv;
  assign in_ready = s1_adv;

  rv32i_imm_pack u_imm_pack (
    .fmt         (s1_fmt_reg),
    .req         (s1_req_reg),
    .instr       (packed_instr),
    .range_fault (range_fault)
  );

  assign s1_err = (s1_fmt_reg == FMT_BAD) || range_fault;

  always_comb begin
    s1_v_next     = s1_v_reg;
    s1_req_next   = s1_req_reg;
    s1_fmt_next   = s1_fmt_reg;
    s2_v_next     = s2_v_reg;
    s2_instr_next = s2_instr_reg;
    s2_err_next   = s2_err_reg;
    cnt_next      = cnt_reg;

    if (s1_adv) begin
      s1_v_next = in_valid;
      if (in_valid) begin
        s1_req_next = in_req;
        s1_fmt_next = decode_fmt(in_op);
      end
    end

    if (s2_adv) begin
      s2_v_next = s1_v_reg;
      if (s1_v_reg) begin
        s2_instr_next = s1_err ? NOP_WORD : packed_instr;
        s2_err_next   = s1_err;
      end
    end

    // Only successfully encoded words that actually leave the pipe are counted.
    if (s2_v_reg && out_ready && !s2_err_reg && (cnt_reg != {CNT_W{1'b1}}))
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_reg     <= 1'b0;
      s1_req_reg   <= '0;
      s1_fmt_reg   <= FMT_BAD;
      s2_v_reg     <= 1'b0;
      s2_instr_reg <= 32'd0;
      s2_err_reg   <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      s1_v_reg     <= s1_v_next;
      s1_req_reg   <= s1_req_next;
      s1_fmt_reg   <= s1_fmt_next;
      s2_v_reg     <= s2_v_next;
      s2_instr_reg <= s2_instr_next;
      s2_err_reg   <= s2_err_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign out_valid = s2_v_reg;
  assign out_instr = s2_instr_reg;
  assign out_err   = s2_err_reg;
  assign enc_count = cnt_reg;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed bench for rv32i_instr_encoder: hand-encoded words, latency, backpressure,
// reset flush and counter saturation (counter narrowed to 4 bits).
module tb_rv32i_instr_encoder;

  localparam int          CNT_W   = 4;
  localparam int          CNT_MAX = 15;
  localparam logic [31:0] NOPW    = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_op;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;

  int n_checks  = 0;
  int n_fail    = 0;
  int stalls    = 0;
  int model_cnt = 0;
  int txn       = 0;

  logic [32:0] exp_q[$];
  logic        held_v = 1'b0;
  logic [32:0] held_word = '0;

  always #5 clk = ~clk;

  rv32i_instr_encoder #(.CNT_W(CNT_W), .NOP_WORD(NOPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Output monitor: scoreboard compare on every output handshake and
  // stability compare while a word is held under backpressure.
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (held_v) begin
          check("hold_instr", out_instr, held_word[31:0]);
          check("hold_err", 32'(out_err), 32'(held_word[32]));
        end
        if (out_ready) begin
          txn++;
          if (exp_q.size() == 0) begin
            check("spurious_out", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("instr", out_instr, e[31:0]);
            check("err", 32'(out_err), 32'(e[32]));
            if (!e[32] && model_cnt < CNT_MAX) model_cnt++;
          end
          $display("txn %0d: instr=0x%08h err=%b enc_count=%0d", txn, out_instr, out_err, enc_count);
        end
      end
      held_v    = !rst && out_valid && !out_ready;
      held_word = {out_err, out_instr};
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Called at posedge+1; leaves in_valid asserted so calls can be chained back-to-back.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] want, input logic want_err);
    int t;
    in_op = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
    end
    if (t == 40) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({want_err, want});
    end
    @(posedge clk); #1;
  endtask

  task automatic send_addi(input int k);
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(k), 32'h0000_0093 | (32'(k) << 20), 1'b0);
  endtask

  task automatic drain();
    int t;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (t == 40) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin : stimulus
    int s0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // ADDI x1,x0,5 with latency check: accept edge, then valid two cycles on.
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_n1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_n2_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    send(7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd2, -32'sd4, 32'hFE21_AE23, 1'b0);        // SW x2,-4(x3)
    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd8, 32'h0000_0463, 1'b0);         // BEQ x0,x0,+8
    send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0010_00EF, 1'b0);      // JAL x1,+2048
    send(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0); // LUI x5
    drain();
    check("enc_count_after_five", 32'(enc_count), 32'd5);

    send(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);         // ADD x3,x1,x2
    send(7'h13, 3'd5, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3, 32'h4033_5293, 1'b0);        // SRAI x5,x6,3
    send(7'h63, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 32'hFE20_9CE3, 1'b0);       // BNE x1,x2,-8
`ifdef IMM_RANGE_CHECK_EN
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, NOPW, 1'b1);
`else
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, 1'b0);
`endif
    send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd1, NOPW, 1'b1);                  // unknown opcode
    drain();
`ifdef IMM_RANGE_CHECK_EN
    check("enc_count_after_faults", 32'(enc_count), 32'd8);
`else
    check("enc_count_after_faults", 32'(enc_count), 32'd9);
`endif

    // Backpressure: two words fill the pipe, then in_ready must stay low.
    out_ready = 1'b0;
    send_addi(1);
    send_addi(2);
    in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    s0 = stalls;
    send_addi(3);  // enters a full pipe while the head drains
    send_addi(4);
    check("bp_no_stall_on_release", 32'(stalls - s0), 32'd0);
    drain();
    check("enc_count_vs_model", 32'(enc_count), 32'(model_cnt));

    // Full-throughput stream.
    s0 = stalls;
    for (int k = 10; k < 16; k++) send_addi(k);
    check("stream_no_bubble", 32'(stalls - s0), 32'd0);
    drain();
    check("enc_count_after_stream", 32'(enc_count), 32'(model_cnt));

    // Reset with two words in flight.
    out_ready = 1'b0;
    send_addi(20);
    send_addi(21);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_enc_count", 32'(enc_count), 32'd0);
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    drain();
    check("postrst_enc_count", 32'(enc_count), 32'd1);

    // Saturation of the 4-bit counter.
    for (int k = 1; k <= 16; k++) send_addi(k);
    drain();
    check("enc_count_saturated", 32'(enc_count), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
